// File: rtl/gray_rr_arbiter_if.sv
// Requester-side bundle for the eight-way Gray-coded round-robin arbiter.
// The arbiter uses the slave view; whoever drives the request lines uses the master view.
interface gray_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_code;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_code,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_code,
    output timeout
  );
endinterface

// File: rtl/gray_rr_arbiter.sv
// Eight-way round-robin arbiter that locks the grant until release, with an optional hold timer.
// The granted index is reported as a 3-bit Gray code; every output comes straight from a flop.
module gray_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic              clk,
  input logic              rst,
  gray_rr_arbiter_if.slave bus
);
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD);

  function automatic logic [2:0] idx_to_gray(input logic [2:0] idx);
    return {idx[2], idx[2] ^ idx[1], idx[1] ^ idx[0]};
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  owner_q, owner_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  gnt_q, gnt_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic        timeout_q, timeout_d;
  logic [15:0] hold_q, hold_d;

  logic        win_found_s;
  logic [2:0]  win_idx_s;
  logic [2:0]  cand_s;

  // Rotating priority search: first requester at or after ptr (mod 8) wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    cand_s      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand_s = ptr_q + 3'(i);
      if (!win_found_s && bus.req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and output logic; release wins over expiry so a coinciding drop is a normal release.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    code_d      = code_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    hold_d      = hold_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_d = 16'd0;
        if (win_found_s) begin
          state_d     = ST_GRANT;
          owner_d     = win_idx_s;
          gnt_d       = 8'd1 << win_idx_s;
          code_d      = idx_to_gray(win_idx_s);
          gnt_valid_d = 1'b1;
          hold_d      = 16'd1;
        end else begin
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!bus.req[owner_q]) begin
          state_d     = ST_IDLE;
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          ptr_d       = owner_q + 3'd1;
          hold_d      = 16'd0;
        end else if ((HOLD_LIMIT != 16'd0) && (hold_q == HOLD_LIMIT)) begin
          state_d     = ST_IDLE;
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          ptr_d       = owner_q + 3'd1;
          hold_d      = 16'd0;
          timeout_d   = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
        hold_d      = 16'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd0;
      owner_q     <= 3'd0;
      code_q      <= 3'b000;
      gnt_q       <= 8'h00;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      code_q      <= code_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_code  = code_q;
  assign bus.timeout   = timeout_q;
endmodule
